// File: rtl/trap_pkg.sv
// Shared types for the trap sequencer.
// States, trap kinds and interrupt cause codes.
package trap_pkg;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_UPDATE,
        S_REDIRECT
    } state_e;

    typedef enum logic {
        K_ENTER,
        K_LEAVE
    } kind_e;

    localparam logic [62:0] INTERRUPT_SOFTWARE = 63'd3;
    localparam logic [62:0] INTERRUPT_TIMER    = 63'd7;
    localparam logic [62:0] INTERRUPT_EXTERNAL = 63'd11;

endpackage

// File: rtl/irq_select.sv
// Interrupt priority encoder.
// Request bits are {ext, timer, sw}; ext beats sw beats timer.
module irq_select
    import trap_pkg::*;
(
    input  logic [2:0]  req_i,
    output logic        any_o,
    output logic [62:0] code_o
);

    // Fixed-priority pick of the highest pending enabled source.
    always_comb begin
        any_o  = |req_i;
        code_o = '0;
        if (req_i[2]) begin
            code_o = INTERRUPT_EXTERNAL;
        end else if (req_i[0]) begin
            code_o = INTERRUPT_SOFTWARE;
        end else if (req_i[1]) begin
            code_o = INTERRUPT_TIMER;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer between commit, data bus and CSR file.
// Drains memory, strobes the CSR update once, then redirects fetch.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [XLEN-1:0] commit_npc,
    input  logic            commit_exc,
    input  logic [62:0]     commit_code,
    input  logic            commit_mret,
    input  logic            mem_busy,
    input  logic            csr_gie,
    input  logic [2:0]      irq_en,
    input  logic [2:0]      irq_pend,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    output logic            trap_enter,
    output logic            trap_leave,
    output logic            trap_irq,
    output logic [62:0]     trap_code,
    output logic [XLEN-1:0] trap_pc,
    output logic            flush,
    output logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready
);

    state_e          state_q, state_d;
    kind_e           kind_q, kind_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [62:0]     code_q, code_d;
    logic            irq_q, irq_d;

    logic            irq_any;
    logic [62:0]     irq_code;
    logic [XLEN-1:0] vec_base;
    logic [XLEN-1:0] vec_off;

    irq_select u_irq_select (
        .req_i  (irq_en & irq_pend),
        .any_o  (irq_any),
        .code_o (irq_code)
    );

    assign vec_base = {csr_mtvec[XLEN-1:2], 2'b00};
    assign vec_off  = XLEN'(code_q) << 2;

    // State and latched trap cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            kind_q  <= K_ENTER;
            pc_q    <= '0;
            code_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            pc_q    <= pc_d;
            code_q  <= code_d;
            irq_q   <= irq_d;
        end
    end

    // Next state, cause latching and per-state outputs.
    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        pc_d           = pc_q;
        code_d         = code_q;
        irq_d          = irq_q;
        trap_enter     = 1'b0;
        trap_leave     = 1'b0;
        trap_irq       = 1'b0;
        trap_code      = '0;
        trap_pc        = '0;
        flush          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        unique case (state_q)
            S_RUN: begin
                if (commit_valid) begin
                    if (commit_exc) begin
                        pc_d    = commit_pc;
                        code_d  = commit_code;
                        irq_d   = 1'b0;
                        kind_d  = K_ENTER;
                        state_d = S_DRAIN;
                    end else if (commit_mret) begin
                        kind_d  = K_LEAVE;
                        state_d = S_DRAIN;
                    end else if (csr_gie && irq_any) begin
                        pc_d    = commit_npc;
                        code_d  = irq_code;
                        irq_d   = 1'b1;
                        kind_d  = K_ENTER;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                flush = 1'b1;
                stall = 1'b1;
                if (!mem_busy) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                flush      = 1'b1;
                stall      = 1'b1;
                trap_enter = (kind_q == K_ENTER);
                trap_leave = (kind_q == K_LEAVE);
                trap_irq   = irq_q;
                trap_code  = code_q;
                trap_pc    = pc_q;
                state_d    = S_REDIRECT;
            end
            S_REDIRECT: begin
                flush          = 1'b1;
                stall          = 1'b1;
                redirect_valid = 1'b1;
                if (kind_q == K_LEAVE) begin
                    redirect_pc = csr_mepc;
                end else if (csr_mtvec[1:0] == 2'b01 && irq_q) begin
                    redirect_pc = vec_base + vec_off;
                end else begin
                    redirect_pc = vec_base;
                end
                if (redirect_ready) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl.
// Vector table drives traps; a queue holds expected CSR strobes.
module tb_trap_ctrl;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic [XLEN-1:0] commit_npc;
    logic            commit_exc;
    logic [62:0]     commit_code;
    logic            commit_mret;
    logic            mem_busy;
    logic            csr_gie;
    logic [2:0]      irq_en;
    logic [2:0]      irq_pend;
    logic [XLEN-1:0] csr_mtvec;
    logic [XLEN-1:0] csr_mepc;
    logic            trap_enter;
    logic            trap_leave;
    logic            trap_irq;
    logic [62:0]     trap_code;
    logic [XLEN-1:0] trap_pc;
    logic            flush;
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;

    trap_ctrl #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_npc     (commit_npc),
        .commit_exc     (commit_exc),
        .commit_code    (commit_code),
        .commit_mret    (commit_mret),
        .mem_busy       (mem_busy),
        .csr_gie        (csr_gie),
        .irq_en         (irq_en),
        .irq_pend       (irq_pend),
        .csr_mtvec      (csr_mtvec),
        .csr_mepc       (csr_mepc),
        .trap_enter     (trap_enter),
        .trap_leave     (trap_leave),
        .trap_irq       (trap_irq),
        .trap_code      (trap_code),
        .trap_pc        (trap_pc),
        .flush          (flush),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cv;
        logic        exc;
        logic        mret;
        logic [62:0] code;
        logic [63:0] pc;
        logic [63:0] npc;
        logic        gie;
        logic [2:0]  en;
        logic [2:0]  pend;
        logic [63:0] mtvec;
        logic [63:0] mepc;
        int          busy;
        int          delay;
        logic        take;
        logic        leave;
        logic        irq;
        logic [62:0] ecode;
        logic [63:0] epc;
        logic [63:0] erpc;
    } vec_t;

    typedef struct {
        logic        leave;
        logic        irq;
        logic [62:0] code;
        logic [63:0] pc;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Compare every CSR strobe against the oldest expected trap.
    always @(negedge clk) begin
        if (trap_enter || trap_leave) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_strobe", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_kind", {62'd0, trap_enter, trap_leave},
                    e.leave ? 64'd1 : 64'd2);
                if (!e.leave) begin
                    chk("sb_irq", {63'd0, trap_irq}, {63'd0, e.irq});
                    chk("sb_code", {1'b0, trap_code}, {1'b0, e.code});
                    chk("sb_pc", trap_pc, e.pc);
                end
            end
        end
    end

    task automatic idle_inputs();
        commit_valid = 1'b0;
        commit_exc   = 1'b0;
        commit_mret  = 1'b0;
        csr_gie      = 1'b0;
        irq_pend     = 3'b000;
    endtask

    task automatic run_vec(input vec_t v);
        int last;
        @(posedge clk);
        #1;
        commit_valid   = v.cv;
        commit_exc     = v.exc;
        commit_mret    = v.mret;
        commit_code    = v.code;
        commit_pc      = v.pc;
        commit_npc     = v.npc;
        csr_gie        = v.gie;
        irq_en         = v.en;
        irq_pend       = v.pend;
        csr_mtvec      = v.mtvec;
        csr_mepc       = v.mepc;
        mem_busy       = (v.busy > 0);
        redirect_ready = 1'b0;
        if (v.take) sbq.push_back('{v.leave, v.irq, v.ecode, v.epc});
        @(negedge clk);
        chk("run_no_flush", {63'd0, flush}, 64'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        if (!v.take) begin
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                chk("notrap_quiet",
                    {59'd0, flush, stall, trap_enter, trap_leave,
                     redirect_valid}, 64'd0);
                @(posedge clk);
                #1;
            end
            return;
        end
        last = 3 + v.busy + v.delay;
        for (int k = 1; k <= last; k++) begin
            mem_busy       = (k <= v.busy);
            redirect_ready = (k == last);
            @(negedge clk);
            chk("trap_flush_stall", {62'd0, flush, stall}, 64'd3);
            if (k == 2 + v.busy) begin
                chk("strobe_time", {62'd0, trap_enter, trap_leave},
                    v.leave ? 64'd1 : 64'd2);
            end else begin
                chk("no_strobe", {62'd0, trap_enter, trap_leave}, 64'd0);
            end
            chk("redir_valid", {63'd0, redirect_valid},
                {63'd0, k >= 3 + v.busy});
            if (k >= 3 + v.busy) chk("redir_pc", redirect_pc, v.erpc);
            @(posedge clk);
            #1;
        end
        redirect_ready = 1'b0;
        @(negedge clk);
        chk("resume_run", {61'd0, flush, stall, redirect_valid}, 64'd0);
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{1, 1, 0, 63'd2, 64'h8000_0010, 64'h8000_0014, 0, 3'b000,
                     3'b000, 64'h8000_1000, 64'h0, 0, 0,
                     1, 0, 0, 63'd2, 64'h8000_0010, 64'h8000_1000};
        vecs[1]  = '{1, 1, 0, 63'd2, 64'h8000_0010, 64'h8000_0014, 0, 3'b000,
                     3'b000, 64'h8000_1000, 64'h0, 3, 0,
                     1, 0, 0, 63'd2, 64'h8000_0010, 64'h8000_1000};
        vecs[2]  = '{1, 0, 0, 63'd0, 64'h8000_0040, 64'h8000_0044, 1, 3'b111,
                     3'b111, 64'h8000_1001, 64'h0, 0, 0,
                     1, 0, 1, 63'd11, 64'h8000_0044, 64'h8000_102C};
        vecs[3]  = '{1, 0, 1, 63'd0, 64'h8000_0080, 64'h8000_0084, 0, 3'b000,
                     3'b000, 64'h8000_1000, 64'h8000_0200, 0, 2,
                     1, 1, 0, 63'd0, 64'h0, 64'h8000_0200};
        vecs[4]  = '{1, 1, 0, 63'd5, 64'h8000_0100, 64'h8000_0104, 1, 3'b010,
                     3'b010, 64'h8000_1001, 64'h0, 0, 0,
                     1, 0, 0, 63'd5, 64'h8000_0100, 64'h8000_1000};
        vecs[5]  = '{1, 0, 0, 63'd0, 64'h8000_0110, 64'h8000_0114, 0, 3'b111,
                     3'b111, 64'h8000_1000, 64'h0, 0, 0,
                     0, 0, 0, 63'd0, 64'h0, 64'h0};
        vecs[6]  = '{1, 0, 0, 63'd0, 64'h8000_0120, 64'h8000_0124, 1, 3'b011,
                     3'b011, 64'h8000_1001, 64'h0, 1, 1,
                     1, 0, 1, 63'd3, 64'h8000_0124, 64'h8000_100C};
        vecs[7]  = '{1, 0, 0, 63'd0, 64'h8000_0130, 64'h8000_0134, 1, 3'b111,
                     3'b010, 64'h8000_2000, 64'h0, 0, 0,
                     1, 0, 1, 63'd7, 64'h8000_0134, 64'h8000_2000};
        vecs[8]  = '{1, 0, 0, 63'd0, 64'h8000_0140, 64'h8000_0144, 1, 3'b100,
                     3'b011, 64'h8000_1000, 64'h0, 0, 0,
                     0, 0, 0, 63'd0, 64'h0, 64'h0};
        vecs[9]  = '{0, 1, 0, 63'd4, 64'h8000_0150, 64'h8000_0154, 1, 3'b111,
                     3'b111, 64'h8000_1000, 64'h0, 0, 0,
                     0, 0, 0, 63'd0, 64'h0, 64'h0};
        vecs[10] = '{1, 1, 1, 63'd1, 64'h8000_0160, 64'h8000_0164, 0, 3'b000,
                     3'b000, 64'h8000_1000, 64'h8000_0900, 0, 0,
                     1, 0, 0, 63'd1, 64'h8000_0160, 64'h8000_1000};
        vecs[11] = '{1, 0, 1, 63'd0, 64'h8000_0170, 64'h8000_0174, 1, 3'b111,
                     3'b111, 64'h8000_1001, 64'h8000_0300, 0, 0,
                     1, 1, 0, 63'd0, 64'h0, 64'h8000_0300};
        vecs[12] = '{1, 0, 0, 63'd0, 64'h8000_0180, 64'h8000_0184, 1, 3'b100,
                     3'b100, 64'h8000_1002, 64'h0, 0, 0,
                     1, 0, 1, 63'd11, 64'h8000_0184, 64'h8000_1000};

        reset          = 1'b1;
        idle_inputs();
        commit_pc      = '0;
        commit_npc     = '0;
        commit_code    = '0;
        mem_busy       = 1'b0;
        irq_en         = 3'b000;
        csr_mtvec      = '0;
        csr_mepc       = '0;
        redirect_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_flags",
            {58'd0, trap_enter, trap_leave, trap_irq, flush, stall,
             redirect_valid}, 64'd0);
        chk("reset_code", {1'b0, trap_code}, 64'd0);
        chk("reset_tpc", trap_pc, 64'd0);
        chk("reset_rpc", redirect_pc, 64'd0);

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Reset while draining: no strobe, straight back to RUN.
        @(posedge clk);
        #1;
        commit_valid = 1'b1;
        commit_exc   = 1'b1;
        commit_code  = 63'd6;
        commit_pc    = 64'h8000_0500;
        mem_busy     = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        chk("rst_in_drain", {62'd0, flush, stall}, 64'd3);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        mem_busy = 1'b0;
        @(negedge clk);
        chk("rst_outs",
            {58'd0, trap_enter, trap_leave, trap_irq, flush, stall,
             redirect_valid}, 64'd0);
        chk("rst_outs_pc", trap_pc | redirect_pc, 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_no_strobe",
                {61'd0, trap_enter, trap_leave, flush}, 64'd0);
        end

        // A trap still runs correctly after the mid-trap reset.
        run_vec(vecs[0]);

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer sitting between the writeback (commit) stage, the data-bus interface and the CSR file. It detects synchronous exceptions, `mret` and enabled pending interrupts at the instruction boundary, and drains outstanding memory traffic. It then issues exactly one `enter`/`leave` update to the CSR file and redirects fetch to the handler or return address through a valid/ready handshake. While a trap is being sequenced it holds the pipeline flushed and stalled.

## Interface
- Parameters:
  - `XLEN`, default 64: width of PCs and CSR values.
- Ports:
  - `clk`  in  1  clock.
  - `reset`  in  1  synchronous, active-high.
  - `commit_valid`  in  1  an instruction retires this cycle.
  - `commit_pc` / `commit_npc`  in  XLEN  PC of the retiring instruction / its architectural next PC.
  - `commit_exc`  in  1  retiring instruction raised a synchronous exception.
  - `commit_code`  in  63  exception cause.
  - `commit_mret`  in  1  retiring instruction is `mret`.
  - `mem_busy`  in  1  data-bus transaction outstanding.
  - `csr_gie`  in  1  `mstatus.mie`.
  - `irq_en`  in  3  `{mie[11], mie[7], mie[3]}`.
  - `irq_pend`  in  3  `{ext, timer, sw}` pending lines.
  - `csr_mtvec`, `csr_mepc`  in  XLEN  current CSR values.
  - `trap_enter` / `trap_leave`  out  1  one-cycle CSR update strobes.
  - `trap_irq`  out  1  cause is an interrupt (drives `mcause[63]`).
  - `trap_code`  out  63  cause code.
  - `trap_pc`  out  XLEN  value to write into `mepc`.
  - `flush` / `stall`  out  1  kill younger instructions / hold fetch.
  - `redirect_valid`  out  1  fetch redirect offered.
  - `redirect_pc`  out  XLEN  redirect target.
  - `redirect_ready`  in  1  fetch accepts the redirect.

## Operation
- FSM states: RUN, DRAIN, UPDATE, REDIRECT. Reset returns to RUN from any state. All outputs and latches reset to 0.
- In RUN, when `commit_valid`=1, priority is exception > mret > interrupt:
  - **Exception:** latch `pc=commit_pc`, `code=commit_code`, `irq=0`, `kind=ENTER`.
  - **mret:** latch `kind=LEAVE`.
  - **Interrupt:** taken when `csr_gie` & |(`irq_en` & `irq_pend`). Priority is ext(11) > sw(3) > timer(7). Latch `pc=commit_npc`, `code` = the selected code, `irq=1`, `kind=ENTER`. The retiring instruction completes normally.
  - Any of the three moves to DRAIN.
- With `commit_valid`=0 nothing is taken, even if interrupts are pending.
- DRAIN: hold until `mem_busy`=0, then go to UPDATE.
- UPDATE: pulse `trap_enter` (ENTER) or `trap_leave` (LEAVE) for exactly one cycle, with `trap_irq`/`trap_code`/`trap_pc` driven from the latches. Then go to REDIRECT.
- REDIRECT: `redirect_valid`=1 with `redirect_pc` computed from CSR values sampled this cycle:
  - LEAVE: `csr_mepc`.
  - ENTER with `csr_mtvec[1:0]`=01 and `irq`=1: `{csr_mtvec[XLEN-1:2],2'b00} + 4*code`.
  - Otherwise: `{csr_mtvec[XLEN-1:2],2'b00}`.
  - Hold `redirect_valid` and `redirect_pc` stable until `redirect_ready`. The ready cycle returns the FSM to RUN.
- `flush`=`stall`=1 in DRAIN, UPDATE and REDIRECT; both are 0 in RUN.
- All commit inputs are ignored outside RUN.
- `trap_code`/`trap_pc`/`trap_irq` drive 0 outside UPDATE.

## Timing
- Trap detected at commit cycle T with `mem_busy`=0: DRAIN at T+1, strobe at T+2, `redirect_valid` from T+3. RUN resumes the cycle after `redirect_ready`.
- Each cycle of `mem_busy`=1 in DRAIN adds one cycle. There is no timeout.
- `redirect_ready` high on the first REDIRECT cycle gives minimum trap latency: 4 cycles from commit back to RUN.
- Exactly one CSR strobe per trap, never both `trap_enter` and `trap_leave` asserted.
- Reset in any state: RUN next cycle, no strobe issued, `redirect_valid` deasserted.
- `irq_pend` dropping after latch does not cancel the trap; the latched cause stands.

## Structure
- Shared package `trap_pkg`:
  - state enum;
  - kind enum {ENTER, LEAVE};
  - interrupt codes `INTERRUPT_SOFTWARE`=3, `INTERRUPT_TIMER`=7, `INTERRUPT_EXTERNAL`=11 (reuse the CSR package definitions if already exported).
- Sub-module `irq_select`: combinational priority encoder taking `irq_en & irq_pend` and producing `any` plus a 63-bit code.
- Everything else lives in `trap_ctrl`.

## Test plan
- **Exception, no drain:** exception at `commit_pc`=0x8000_0010, code 2, `mem_busy`=0, mtvec=0x8000_1000.
  - Required: `trap_enter` at T+2 with code 2, `trap_pc`=0x8000_0010, `trap_irq`=0.
  - Required: `redirect_pc`=0x8000_1000 at T+3; `flush` high T+1..T+3.
- **Drain wait:** same trap with `mem_busy` held for 3 cycles.
  - Required: strobe delayed to T+5; `stall` stays high throughout.
- **Simultaneous interrupts, vectored:** `csr_gie`=1, `irq_en`=3'b111, `irq_pend`=3'b111, `commit_npc`=0x8000_0044, mtvec=0x8000_1001.
  - Required: code 11, `trap_irq`=1, `trap_pc`=0x8000_0044, `redirect_pc`=0x8000_102C.
- **mret backpressure:** `commit_mret` with `csr_mepc`=0x8000_0200 and `redirect_ready` low for 2 cycles.
  - Required: single `trap_leave`; `redirect_valid` with 0x8000_0200 held stable 3 cycles.
- **Exception beats interrupt:** same-cycle `commit_exc` code 5 and a pending enabled timer interrupt.
  - Required: code 5, `trap_irq`=0, `trap_pc`=`commit_pc`.
  - Required: with `csr_gie`=0, a pending interrupt alone produces no trap.
- **Reset mid-trap:** assert `reset` in DRAIN.
  - Required: next cycle RUN, all outputs 0, no strobe seen.
